// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: a valid/ready command becomes one APB
// SETUP/ACCESS transfer, and the result returns on a valid/ready response stream.
module apb_master_bridge #(
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  // response stream
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB4 requester port
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Counter value on the last PREADY-low ACCESS cycle before the abort.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // NOTE: every state/output register is written with <= so all updates in
  // this block see the pre-edge values, independent of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            // The command lands directly in the APB output registers;
            // reads drive zero data and strobes as APB4 requires.
            cmd_ready <= 1'b0;
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
            PSTRB     <= cmd_write ? cmd_strb  : '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          PSEL    <= 1'b1;
          PENABLE <= 1'b0;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            wait_cnt    <= wait_cnt + CNT_W'(1);
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a memory-backed APB slave model
// and per-transaction expectations derived from the bridge's timing rules.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];

  // Command presented while the previous response is still pending.
  logic        nx_wr;
  logic [7:0]  nx_addr;
  logic [31:0] nx_wdata;
  logic [3:0]  nx_strb;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .PADDR_SIZE(8), .PDATA_SIZE(32), .TIMEOUT(TIMEOUT), .CNT_W(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  // One complete transfer; entered and left at a falling edge.
  // waits = PREADY-low ACCESS cycles before PREADY rises (>= TIMEOUT aborts).
  task automatic run_txn(input string tag, input bit wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int waits, input bit slverr, input int rsp_delay,
                         input bit hold_next);
    bit          to;
    int          done;
    logic [31:0] exp_rdata;
    logic [44:0] exp_fields;
    logic [33:0] exp_rsp;
    logic [3:0]  exp_ctl;
    to         = (TIMEOUT != 0) && (waits >= TIMEOUT);
    done       = to ? 2 + TIMEOUT : 3 + waits;
    exp_rdata  = (wr || to) ? 32'h0 : mem[addr];
    exp_fields = {addr, wr, (wr ? wdata : 32'h0), (wr ? strb : 4'h0)};
    exp_rsp    = {exp_rdata, (to || slverr), to};

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: cmd_ready=%b want 1", tag, cmd_ready);
    end
    @(posedge PCLK); @(negedge PCLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = $urandom; cmd_write = $urandom_range(1);

    for (int c = 0; c <= done; c++) begin
      if (c > 0) begin @(posedge PCLK); @(negedge PCLK); end
      exp_ctl = {(c >= 1 && c < done), (c >= 2 && c < done), (c == done), 1'b0};
      total++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== exp_ctl) begin
        bad++;
        $display("FAIL %s ctl c=%0d: sel/en/rv/cr=%b want %b", tag, c,
                 {PSEL, PENABLE, rsp_valid, cmd_ready}, exp_ctl);
      end
      if (c >= 1 && c < done) begin
        total++;
        if ({PADDR, PWRITE, PWDATA, PSTRB} !== exp_fields) begin
          bad++;
          $display("FAIL %s bus c=%0d: addr/wr/wdata/strb=%h want %h", tag, c,
                   {PADDR, PWRITE, PWDATA, PSTRB}, exp_fields);
        end
      end
      if (c == done) begin
        total++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== exp_rsp) begin
          bad++;
          $display("FAIL %s rsp: rdata/err/to=%h want %h", tag,
                   {rsp_rdata, rsp_err, rsp_timeout}, exp_rsp);
        end
      end
      // Slave drive for the next edge; PSLVERR is high on every wait cycle.
      if (c >= 2 && c < done && (c - 2) == waits) begin
        PREADY = 1'b1; PSLVERR = slverr; PRDATA = mem[addr];
      end else if (c >= 2 && c < done) begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
      end
    end

    if (wr && !to && !slverr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[addr][8*b +: 8] = wdata[8*b +: 8];

    if (hold_next) begin
      cmd_valid = 1'b1; cmd_write = nx_wr; cmd_addr = nx_addr;
      cmd_wdata = nx_wdata; cmd_strb = nx_strb;
    end
    for (int d = 0; d < rsp_delay; d++) begin
      rsp_ready = 1'b0;
      @(posedge PCLK); @(negedge PCLK);
      total++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, PSEL} !==
          {1'b1, exp_rsp, 2'b00}) begin
        bad++;
        $display("FAIL %s hold d=%0d: rv/rsp/cr/sel=%h want %h", tag, d,
                 {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, PSEL},
                 {1'b1, exp_rsp, 2'b00});
      end
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin
      bad++;
      $display("FAIL %s drain: rv/cr/sel=%b want 010", tag, {rsp_valid, cmd_ready, PSEL});
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(negedge PCLK);
    total++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE,
         PADDR, PWRITE, PWDATA, PSTRB} !== '0) begin
      bad++;
      $display("FAIL reset outputs: some output nonzero, cr=%b rv=%b sel=%b en=%b",
               cmd_ready, rsp_valid, PSEL, PENABLE);
    end
    PRESETn = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    run_txn("wr0", 1'b1, 8'h04, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_read_waits();
    mem[8'h08] = 32'h1234_5678;
    run_txn("rd3", 1'b0, 8'h08, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_slave_error();
    run_txn("slverr", 1'b1, 8'h3C, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 1, 1'b0);
    run_txn("slverr_ign", 1'b0, 8'h3C, 32'h0, 4'h0, 4, 1'b0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 8'h10, 32'h0, 4'h0, TIMEOUT, 1'b0, 2, 1'b0);
    run_txn("ready_at_limit", 1'b0, 8'h10, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    nx_wr = 1'b0; nx_addr = 8'h20; nx_wdata = 32'h0; nx_strb = 4'h0;
    run_txn("bp_first", 1'b1, 8'h20, 32'h0BAD_F00D, 4'b0101, 1, 1'b0, 5, 1'b1);
    run_txn("bp_second", nx_wr, nx_addr, nx_wdata, nx_strb, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; cmd_wdata = '0; cmd_strb = '0;
    @(posedge PCLK); @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0;
    repeat (3) begin @(posedge PCLK); @(negedge PCLK); end
    total++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      bad++;
      $display("FAIL arst pre: sel/en=%b want 11", {PSEL, PENABLE});
    end
    #2 PRESETn = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL arst drop: sel/en/rv/cr=%b want 0000",
               {PSEL, PENABLE, rsp_valid, cmd_ready});
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    total++;
    if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin
      bad++;
      $display("FAIL arst release: cr/rv/sel=%b want 100", {cmd_ready, rsp_valid, PSEL});
    end
    run_txn("arst_read", 1'b0, 8'h30, 32'h0, 4'h0, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit   wr;
      int   waits;
      wr    = $urandom_range(1);
      waits = ($urandom_range(7) == 0) ? TIMEOUT + $urandom_range(3) : $urandom_range(4);
      run_txn($sformatf("rand%0d", n), wr, 8'($urandom_range(15) * 4), $urandom,
              4'($urandom), waits, ($urandom_range(3) == 0), $urandom_range(3), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
